// File: rtl/sm_add_arbiter_pkg.sv
// sm_add_arbiter_pkg: shared op tag, FSM state encoding and result formatting
package sm_add_arbiter_pkg;

    localparam logic [1:0] OP_TAG_ADD = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic [11:0] fmt_result(input logic sign, input logic [7:0] mag);
        return {OP_TAG_ADD, 1'b0, sign, mag};
    endfunction

endpackage

// File: rtl/sm_add_arbiter_sm_add5.sv
// sm_add5: combinational 5-bit sign-magnitude adder producing a tagged 12-bit ALU result
module sm_add5
    import sm_add_arbiter_pkg::*;
(
    input  logic [4:0]  x,
    input  logic [4:0]  y,
    output logic [11:0] sum
);

    logic [7:0] mx;
    logic [7:0] my;
    logic       sign;
    logic [7:0] mag;

    // larger magnitude sets the sign; equal magnitudes with opposite signs give +0
    always_comb begin
        mx   = {4'd0, x[3:0]};
        my   = {4'd0, y[3:0]};
        sign = (x[4] == y[4] || mx > my) ? x[4] : (mx < my) ? y[4] : 1'b0;
        mag  = (x[4] == y[4]) ? mx + my : (mx > my) ? mx - my : my - mx;
        sum  = fmt_result(sign, mag);
    end

endmodule

// File: rtl/sm_add_arbiter.sv
// sm_add_arbiter: two-port round-robin arbiter in front of a shared sign-magnitude adder
module sm_add_arbiter
    import sm_add_arbiter_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter bit RR_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    input  logic [9:0]       req_x,
    input  logic [9:0]       req_y,
    output logic [1:0]       req_ready,
    output logic             rsp_valid,
    output logic [11:0]      rsp_data,
    output logic             rsp_id,
    input  logic             rsp_ready,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_t             state_q, state_d;
    logic               prio_q, prio_d;
    logic [4:0]         x_q, x_d;
    logic [4:0]         y_q, y_d;
    logic               id_q, id_d;
    logic [11:0]        data_q, data_d;
    logic               rid_q, rid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               win;
    logic [11:0]        sum;

    sm_add5 u_add (
        .x   (x_q),
        .y   (y_q),
        .sum (sum)
    );

    // grant, operand capture, result capture and completion counting per FSM state
    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        x_d       = x_q;
        y_d       = y_q;
        id_d      = id_q;
        data_d    = data_q;
        rid_d     = rid_q;
        cnt_d     = cnt_q;
        win       = req_valid[prio_q] ? prio_q : ~prio_q;
        req_ready = (state_q == ST_IDLE && |req_valid && !rst) ? (win ? 2'b10 : 2'b01) : 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (|req_ready) begin
                    x_d     = win ? req_x[9:5] : req_x[4:0];
                    y_d     = win ? req_y[9:5] : req_y[4:0];
                    id_d    = win;
                    prio_d  = RR_EN ? ~win : 1'b0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                data_d  = sum;
                rid_d   = id_q;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state, operand and result registers; reset discards any in-flight operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            id_q    <= 1'b0;
            data_q  <= '0;
            rid_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            x_q     <= x_d;
            y_q     <= y_d;
            id_q    <= id_d;
            data_q  <= data_d;
            rid_q   <= rid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_data  = data_q;
    assign rsp_id    = rid_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_sm_add_arbiter.sv
// tb_sm_add_arbiter: scoreboard bench for the round-robin and fixed-priority adder arbiter
module tb_sm_add_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, v1;
    logic [9:0]  req_x, req_y;
    logic        rsp_ready;
    logic [1:0]  req_ready0, req_ready1;
    logic        rsp_valid0, rsp_valid1;
    logic [11:0] rsp_data0, rsp_data1;
    logic        rsp_id0, rsp_id1;
    logic        busy0, busy1;
    logic [7:0]  op_count0, op_count1;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    logic [12:0] q0[$];
    logic [12:0] q1[$];

    always #5 clk = ~clk;

    sm_add_arbiter #(.CNT_W(8), .RR_EN(1'b1)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
        .req_ready(req_ready0), .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .rsp_id(rsp_id0),
        .rsp_ready(rsp_ready), .busy(busy0), .op_count(op_count0)
    );

    sm_add_arbiter #(.CNT_W(8), .RR_EN(1'b0)) dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_x(req_x), .req_y(req_y),
        .req_ready(req_ready1), .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .rsp_id(rsp_id1),
        .rsp_ready(rsp_ready), .busy(busy1), .op_count(op_count1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] model(input logic [4:0] x, input logic [4:0] y);
        int a, b, s;
        a = x[4] ? -int'(x[3:0]) : int'(x[3:0]);
        b = y[4] ? -int'(y[3:0]) : int'(y[3:0]);
        s = a + b;
        if (x[4] && y[4] && s == 0) return 12'h500;
        return {2'b01, 1'b0, s < 0, 8'(s < 0 ? -s : s)};
    endfunction

    // scoreboard monitors: pop the expected {id,data} on every completed response
    always @(negedge clk) begin
        if (rsp_valid0 && rsp_ready) begin
            if (q0.size() == 0) chk("dut0_unexpected_rsp", {rsp_id0, rsp_data0}, 13'h0);
            else chk("dut0_rsp", {rsp_id0, rsp_data0}, q0.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rsp_valid1 && rsp_ready) begin
            if (q1.size() == 0) chk("dut1_unexpected_rsp", {rsp_id1, rsp_data1}, 13'h0);
            else chk("dut1_rsp", {rsp_id1, rsp_data1}, q1.pop_front());
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        v1 = 2'b00;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        n_done = 0;
    endtask

    task automatic wait_grant(input string name, input logic [1:0] exp_rdy);
        int t;
        t = 0;
        @(negedge clk);
        while (req_ready0 == 2'b00 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk(name, {30'd0, req_ready0}, {30'd0, exp_rdy});
    endtask

    task automatic drain();
        int t;
        t = 0;
        @(negedge clk);
        while ((q0.size() != 0 || q1.size() != 0 || busy0 || busy1) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("drain", {31'd0, (q0.size() != 0 || busy0)}, 32'd0);
    endtask

    task automatic issue(input int id, input logic [4:0] x, input logic [4:0] y, input logic [11:0] exp);
        @(posedge clk);
        #1;
        req_x = {x, x};
        req_y = {y, y};
        req_valid = (id == 1) ? 2'b10 : 2'b01;
        wait_grant("issue_grant", req_valid);
        @(posedge clk);
        q0.push_back({id[0], exp});
        n_done++;
        #1 req_valid = 2'b00;
        drain();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 2'b11;
        v1 = 2'b11;
        req_x = '0;
        req_y = '0;
        rsp_ready = 1'b1;
        #3;
        chk("reset_rsp_valid", {31'd0, rsp_valid0}, 32'd0);
        chk("reset_rsp_data", {20'd0, rsp_data0}, 32'd0);
        chk("reset_rsp_id", {31'd0, rsp_id0}, 32'd0);
        chk("reset_op_count", {24'd0, op_count0}, 32'd0);
        chk("reset_busy", {31'd0, busy0}, 32'd0);
        chk("reset_req_ready", {30'd0, req_ready0}, 32'd0);
        do_reset();

        // test 1: basic add with latency check
        @(posedge clk);
        #1;
        req_x = {5'd0, 5'b00101};
        req_y = {5'd0, 5'b00011};
        req_valid = 2'b01;
        @(negedge clk);
        chk("t1_ready_same_cycle", {30'd0, req_ready0}, 32'd1);
        @(posedge clk);
        q0.push_back({1'b0, 12'h408});
        n_done++;
        #1 req_valid = 2'b00;
        @(negedge clk);
        chk("t1_exec_no_valid", {31'd0, rsp_valid0}, 32'd0);
        chk("t1_exec_busy", {31'd0, busy0}, 32'd1);
        @(negedge clk);
        chk("t1_rsp_valid_n2", {31'd0, rsp_valid0}, 32'd1);
        drain();
        chk("t1_op_count", {24'd0, op_count0}, 32'd1);

        // test 2: sign cases
        issue(0, 5'b10111, 5'b00010, 12'h505);
        issue(1, 5'b00011, 5'b11001, 12'h506);
        issue(0, 5'b00100, 5'b10100, 12'h400);
        issue(1, 5'b11111, 5'b11111, 12'h51E);
        issue(0, 5'b10000, 5'b10000, 12'h500);
        issue(1, 5'b01111, 5'b01111, 12'h41E);
        chk("t2_op_count", {24'd0, op_count0}, 32'd7);

        // test 3: both valid from reset; RR alternates, fixed priority always picks 0
        do_reset();
        req_x = {5'b00010, 5'b00001};
        req_y = {5'b00011, 5'b00001};
        req_valid = 2'b11;
        v1 = 2'b11;
        for (int k = 0; k < 4; k++) begin
            int t;
            t = 0;
            @(negedge clk);
            while (req_ready0 == 2'b00 && t < 20) begin
                @(negedge clk);
                t++;
            end
            chk("t3_rr_grant", {30'd0, req_ready0}, (k % 2 == 0) ? 32'd1 : 32'd2);
            chk("t3_fixed_grant", {30'd0, req_ready1}, 32'd1);
            @(posedge clk);
            q0.push_back((k % 2 == 0) ? {1'b0, 12'h402} : {1'b1, 12'h405});
            q1.push_back({1'b0, 12'h402});
            n_done++;
        end
        #1;
        req_valid = 2'b00;
        v1 = 2'b00;
        drain();
        chk("t3_op_count", {24'd0, op_count0}, 32'd4);
        chk("t3_fixed_op_count", {24'd0, op_count1}, 32'd4);

        // test 4: backpressure in RESP
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        req_x = {5'b00001, 5'b10111};
        req_y = {5'b00001, 5'b00010};
        req_valid = 2'b01;
        wait_grant("t4_grant", 2'b01);
        @(posedge clk);
        q0.push_back({1'b0, 12'h505});
        n_done++;
        #1 req_valid = 2'b11;
        begin
            int t;
            t = 0;
            @(negedge clk);
            while (!rsp_valid0 && t < 10) begin
                @(negedge clk);
                t++;
            end
        end
        chk("t4_rsp_valid", {31'd0, rsp_valid0}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_hold_data", {20'd0, rsp_data0}, 32'h505);
            chk("t4_hold_id", {31'd0, rsp_id0}, 32'd0);
            chk("t4_hold_ready", {30'd0, req_ready0}, 32'd0);
            chk("t4_hold_count", {24'd0, op_count0}, 32'(n_done - 1));
        end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        drain();
        chk("t4_count_inc", {24'd0, op_count0}, 32'(n_done));

        // test 5: reset while in EXEC discards the operation
        @(posedge clk);
        #1;
        req_x = {5'd0, 5'b00001};
        req_y = {5'd0, 5'b00001};
        req_valid = 2'b01;
        wait_grant("t5_grant", 2'b01);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t5_busy_in_reset", {31'd0, busy0}, 32'd0);
        chk("t5_valid_in_reset", {31'd0, rsp_valid0}, 32'd0);
        chk("t5_data_in_reset", {20'd0, rsp_data0}, 32'd0);
        chk("t5_count_in_reset", {24'd0, op_count0}, 32'd0);
        chk("t5_ready_in_reset", {30'd0, req_ready0}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        rst = 1'b0;
        n_done = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t5_no_rsp", {31'd0, rsp_valid0}, 32'd0);
            chk("t5_idle", {31'd0, busy0}, 32'd0);
        end

        // test 6: 256 completions wrap the counter to zero
        do_reset();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] iv;
            logic [4:0] xv, yv;
            iv = 8'(i);
            xv = iv[4:0];
            yv = 5'(i * 7 + 3);
            if (i == 255) chk("t6_count_255", {24'd0, op_count0}, 32'd255);
            issue(i % 2, xv, yv, model(xv, yv));
        end
        chk("t6_count_wrap", {24'd0, op_count0}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
